// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_pkg
//  Description : Shared state encodings and framing constants for the
//                program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    // Loader sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_LEN_H  = 3'd2,
        ST_LEN_L  = 3'd3,
        ST_DATA_H = 3'd4,
        ST_DATA_L = 3'd5,
        ST_CSUM   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    // Start-of-frame byte
    localparam logic [7:0] LOADER_MAGIC = 8'hA5;

    // True while a frame is being received (header through checksum)
    function automatic logic in_frame(input state_t s);
        return (s inside {ST_LEN_H, ST_LEN_L, ST_DATA_H, ST_DATA_L, ST_CSUM});
    endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_rx_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_rx_timeout
//  Description : Idle-cycle counter. Counts enabled cycles without a clear and
//                pulses o_timeout on the TIMEOUT_CYCLES-th such cycle, unless
//                a clear arrives in that same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader_rx_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_timeout
);

    localparam int             CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // cnt_q holds the number of idle cycles already elapsed, so the current
    // idle cycle is the last allowed one when cnt_q == LAST
    assign o_timeout = i_en && !i_clr && (cnt_q == LAST);

    // Idle counter: restarts on every byte and whenever no frame is active
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (!i_en || i_clr) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Boot/reload sequencer. Receives a framed program image over a
//                byte stream, writes it as 16-bit words into RAM and holds the
//                core in reset meanwhile. Otherwise passes core writes through.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [15:0] LOAD_BASE      = 16'h0000,
    parameter int          BOOT_WAIT      = 1,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    input  logic [15:0] i_core_waddr,
    input  logic [15:0] i_core_wdata,
    input  logic        i_core_wstrobe,
    output logic [15:0] o_mem_waddr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_we,
    output logic        o_core_rst,
    output logic        o_busy,
    output logic        o_error,
    output logic [15:0] o_words_loaded
);

    localparam state_t RESET_STATE = (BOOT_WAIT != 0) ? ST_IDLE : ST_RUN;

    state_t      state_q, state_d;
    logic [7:0]  len_h_q, len_h_d;
    logic [15:0] rem_q,   rem_d;
    logic [7:0]  hi_q,    hi_d;
    logic [7:0]  acc_q,   acc_d;
    logic [15:0] words_q, words_d;
    logic        we_q,    we_d;
    logic [15:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;

    logic        take;
    logic        timeout;
    logic [15:0] len_full;

    // No backpressure: every byte presented outside reset is consumed
    assign o_rx_ready = !i_rst;
    assign take       = i_rx_valid && o_rx_ready;
    assign len_full   = {len_h_q, i_rx_data};

    assign o_busy         = in_frame(state_q);
    assign o_error        = (state_q == ST_ERR);
    assign o_core_rst     = (state_q != ST_RUN);
    assign o_words_loaded = words_q;

    program_loader_rx_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (o_busy),
        .i_clr     (take),
        .o_timeout (timeout)
    );

    // Frame parser: next state, word assembly, checksum and write request
    always_comb begin
        state_d = state_q;
        len_h_d = len_h_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        acc_d   = acc_q;
        words_d = words_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (take) begin
            case (state_q)
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (i_rx_data == LOADER_MAGIC) begin
                        state_d = ST_LEN_H;
                        words_d = '0;
                        acc_d   = '0;
                    end
                end
                ST_LEN_H: begin
                    len_h_d = i_rx_data;
                    state_d = ST_LEN_L;
                end
                ST_LEN_L: begin
                    rem_d   = len_full;
                    state_d = (len_full == 16'd0) ? ST_CSUM : ST_DATA_H;
                end
                ST_DATA_H: begin
                    hi_d    = i_rx_data;
                    acc_d   = acc_q ^ i_rx_data;
                    state_d = ST_DATA_L;
                end
                ST_DATA_L: begin
                    acc_d   = acc_q ^ i_rx_data;
                    we_d    = 1'b1;
                    waddr_d = LOAD_BASE + words_q;
                    wdata_d = {hi_q, i_rx_data};
                    words_d = words_q + 16'd1;
                    rem_d   = rem_q - 16'd1;
                    state_d = (rem_q == 16'd1) ? ST_CSUM : ST_DATA_H;
                end
                ST_CSUM: begin
                    state_d = (i_rx_data == acc_q) ? ST_RUN : ST_ERR;
                end
                default: state_d = RESET_STATE;
            endcase
        end else if (timeout) begin
            state_d = ST_ERR;
        end
    end

    // Loader state registers; reset abandons any frame in progress
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RESET_STATE;
            len_h_q <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            acc_q   <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_h_q <= len_h_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            acc_q   <= acc_d;
            words_q <= words_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // RAM port mux: loader owns the port whenever the core is held in reset
    always_comb begin
        o_mem_waddr = i_core_waddr;
        o_mem_wdata = i_core_wdata;
        o_mem_we    = i_core_wstrobe;
        if (o_core_rst) begin
            o_mem_waddr = waddr_q;
            o_mem_wdata = wdata_q;
            o_mem_we    = we_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Self-checking bench for program_loader (TIMEOUT_CYCLES=16,
//                LOAD_BASE=0, BOOT_WAIT=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam logic [15:0] LOAD_BASE = 16'h0000;
    localparam int          TMO       = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] core_waddr;
    logic [15:0] core_wdata;
    logic        core_wstrobe;
    logic [15:0] mem_waddr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        core_rst;
    logic        busy;
    logic        error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    // Loader-side RAM writes seen on the port, {addr, data}
    logic [31:0] wlog[$];

    program_loader #(
        .LOAD_BASE      (LOAD_BASE),
        .BOOT_WAIT      (1),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .o_rx_ready     (rx_ready),
        .i_core_waddr   (core_waddr),
        .i_core_wdata   (core_wdata),
        .i_core_wstrobe (core_wstrobe),
        .o_mem_waddr    (mem_waddr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_we       (mem_we),
        .o_core_rst     (core_rst),
        .o_busy         (busy),
        .o_error        (error),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we && core_rst) wlog.push_back({mem_waddr, mem_wdata});
    end

    // Called at a negedge; presents one byte for exactly one cycle
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i]);
    endtask

    // Compare log entries from 'base' onward against the expected write list
    task automatic check_writes(input string name, input int base, input logic [31:0] exp[$]);
        checks++;
        if (wlog.size() - base != exp.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wlog.size() - base, exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (wlog[base + i] !== exp[i]) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got %h expected %h", name, i, wlog[base + i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
        core_waddr = '0; core_wdata = '0; core_wstrobe = 1'b0;
        @(negedge clk);
        checks++;
        if ({rx_ready, core_rst, mem_we, busy, error, words_loaded} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b crst=%b we=%b busy=%b err=%b words=%0d expected 0 1 0 0 0 0",
                     rx_ready, core_rst, mem_we, busy, error, words_loaded);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", rx_ready); end
        // Non-magic byte in IDLE is dropped
        send_byte(8'h3C);
        checks++;
        if ({busy, core_rst} !== 2'b01) begin
            errors++; $display("FAIL idle_drop: got busy=%b crst=%b expected 0 1", busy, core_rst);
        end
        // Reset mid-frame, after one word has been written
        send_bytes('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34});
        checks++;
        if (words_loaded !== 16'd1) begin errors++; $display("FAIL mid_words: got %0d expected 1", words_loaded); end
        #2;
        rst = 1'b1; core_wstrobe = 1'b1; core_waddr = 16'h0100; core_wdata = 16'h5555;
        #1;
        checks++;
        if ({core_rst, mem_we, error, busy, words_loaded} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL mid_reset: got crst=%b we=%b err=%b busy=%b words=%0d expected 1 0 0 0 0",
                     core_rst, mem_we, error, busy, words_loaded);
        end
        @(negedge clk);
        core_wstrobe = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_frame;
        int base;
        logic [31:0] exp[$];
        base = wlog.size();
        send_byte(8'hA5);
        checks++;
        if ({busy, core_rst, words_loaded} !== {1'b1, 1'b1, 16'd0}) begin
            errors++; $display("FAIL good_hdr: got busy=%b crst=%b words=%0d expected 1 1 0", busy, core_rst, words_loaded);
        end
        send_bytes('{8'h00, 8'h02, 8'h12, 8'h34});
        checks++;
        if ({mem_we, mem_waddr, mem_wdata, words_loaded} !== {1'b1, 16'h0000, 16'h1234, 16'd1}) begin
            errors++; $display("FAIL good_w0: got we=%b %h@%h words=%0d expected 1 1234@0000 1", mem_we, mem_wdata, mem_waddr, words_loaded);
        end
        send_byte(8'hAB);
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL good_we_pulse: got %b expected 0", mem_we); end
        send_byte(8'hCD);
        checks++;
        if ({mem_we, mem_waddr, mem_wdata, words_loaded, core_rst} !== {1'b1, 16'h0001, 16'hABCD, 16'd2, 1'b1}) begin
            errors++; $display("FAIL good_w1: got we=%b %h@%h words=%0d crst=%b expected 1 abcd@0001 2 1",
                               mem_we, mem_wdata, mem_waddr, words_loaded, core_rst);
        end
        send_byte(8'h40);
        checks++;
        if ({core_rst, error, busy, words_loaded} !== {1'b0, 1'b0, 1'b0, 16'd2}) begin
            errors++; $display("FAIL good_release: got crst=%b err=%b busy=%b words=%0d expected 0 0 0 2",
                               core_rst, error, busy, words_loaded);
        end
        idle(2);
        exp = '{{LOAD_BASE, 16'h1234}, {LOAD_BASE + 16'd1, 16'hABCD}};
        check_writes("good", base, exp);
    endtask

    task automatic test_bad_csum;
        int base;
        logic [31:0] exp[$];
        base = wlog.size();
        send_bytes('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41});
        checks++;
        if ({error, core_rst, busy, words_loaded} !== {1'b1, 1'b1, 1'b0, 16'd2}) begin
            errors++; $display("FAIL bad_csum: got err=%b crst=%b busy=%b words=%0d expected 1 1 0 2",
                               error, core_rst, busy, words_loaded);
        end
        idle(3);
        checks++;
        if ({error, core_rst} !== 2'b11) begin errors++; $display("FAIL err_sticky: got err=%b crst=%b expected 1 1", error, core_rst); end
        send_byte(8'hA5);
        checks++;
        if ({error, busy, core_rst} !== 3'b011) begin
            errors++; $display("FAIL err_clear: got err=%b busy=%b crst=%b expected 0 1 1", error, busy, core_rst);
        end
        send_bytes('{8'h00, 8'h01, 8'h77, 8'h88, 8'hFF});
        checks++;
        if ({error, core_rst, words_loaded} !== {1'b0, 1'b0, 16'd1}) begin
            errors++; $display("FAIL err_recover: got err=%b crst=%b words=%0d expected 0 0 1", error, core_rst, words_loaded);
        end
        idle(2);
        exp = '{{LOAD_BASE, 16'h1234}, {LOAD_BASE + 16'd1, 16'hABCD}, {LOAD_BASE, 16'h7788}};
        check_writes("bad_then_good", base, exp);
    endtask

    task automatic test_empty_frame;
        int base;
        logic [31:0] exp[$];
        base = wlog.size();
        send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00});
        checks++;
        if ({core_rst, error, busy, words_loaded} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
            errors++; $display("FAIL empty: got crst=%b err=%b busy=%b words=%0d expected 0 0 0 0", core_rst, error, busy, words_loaded);
        end
        core_waddr = 16'h0100; core_wdata = 16'h5555; core_wstrobe = 1'b1;
        #1;
        checks++;
        if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 16'h0100, 16'h5555}) begin
            errors++; $display("FAIL passthru: got we=%b %h@%h expected 1 5555@0100", mem_we, mem_wdata, mem_waddr);
        end
        @(negedge clk);
        core_wstrobe = 1'b0;
        idle(1);
        exp = {};
        check_writes("empty", base, exp);
    endtask

    task automatic test_timeout;
        send_bytes('{8'hA5, 8'h00});
        idle(TMO - 1);
        checks++;
        if ({busy, error} !== 2'b10) begin errors++; $display("FAIL tmo_before: got busy=%b err=%b expected 1 0", busy, error); end
        idle(1);
        checks++;
        if ({busy, error, core_rst} !== 3'b011) begin
            errors++; $display("FAIL tmo_hit: got busy=%b err=%b crst=%b expected 0 1 1", busy, error, core_rst);
        end
        send_bytes('{8'hA5, 8'h00});
        idle(TMO - 1);
        send_byte(8'h01);
        checks++;
        if ({busy, error} !== 2'b10) begin errors++; $display("FAIL tmo_race: got busy=%b err=%b expected 1 0", busy, error); end
        send_bytes('{8'h12, 8'h34, 8'h26});
        checks++;
        if ({core_rst, error} !== 2'b00) begin errors++; $display("FAIL tmo_recover: got crst=%b err=%b expected 0 0", core_rst, error); end
    endtask

    task automatic test_run_reload;
        send_byte(8'h3C);
        checks++;
        if ({busy, core_rst, error} !== 3'b000) begin
            errors++; $display("FAIL run_drop: got busy=%b crst=%b err=%b expected 0 0 0", busy, core_rst, error);
        end
        core_waddr = 16'h0200; core_wdata = 16'h1111; core_wstrobe = 1'b1;
        rx_data = 8'hA5; rx_valid = 1'b1;
        #1;
        checks++;
        if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 16'h0200, 16'h1111}) begin
            errors++; $display("FAIL reload_same_cycle: got we=%b %h@%h expected 1 1111@0200", mem_we, mem_wdata, mem_waddr);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({core_rst, mem_we} !== 2'b10) begin
            errors++; $display("FAIL reload_block: got crst=%b we=%b expected 1 0", core_rst, mem_we);
        end
        core_wstrobe = 1'b0;
        send_bytes('{8'h00, 8'h00, 8'h00});
        checks++;
        if (core_rst !== 1'b0) begin errors++; $display("FAIL reload_release: got %b expected 0", core_rst); end
    endtask

    // Random frames against a word-list model of the image format
    task automatic test_random;
        for (int f = 0; f < 20; f++) begin
            int          base;
            int          len;
            bit          bad;
            logic [7:0]  csum;
            logic [7:0]  bs[$];
            logic [31:0] exp[$];
            logic [15:0] w;
            logic [7:0]  junk;
            base = wlog.size();
            len  = $urandom_range(0, 6);
            bad  = ($urandom_range(0, 9) < 3);
            csum = 8'h00;
            exp  = {};
            bs   = '{8'hA5, 8'h00, 8'(len)};
            for (int i = 0; i < len; i++) begin
                w = 16'($urandom);
                bs.push_back(w[15:8]);
                bs.push_back(w[7:0]);
                csum = csum ^ w[15:8] ^ w[7:0];
                exp.push_back({LOAD_BASE + 16'(i), w});
            end
            if (bad) csum = csum ^ 8'($urandom_range(1, 255));
            bs.push_back(csum);
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk);
            end
            foreach (bs[i]) begin
                send_byte(bs[i]);
                idle($urandom_range(0, 3));
            end
            checks++;
            if ({error, core_rst, busy, words_loaded} !== {bad, bad, 1'b0, 16'(len)}) begin
                errors++; $display("FAIL rand%0d status: got err=%b crst=%b busy=%b words=%0d expected %b %b 0 %0d",
                                   f, error, core_rst, busy, words_loaded, bad, bad, len);
            end
            idle(2);
            check_writes("rand", base, exp);
        end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_csum;
        test_empty_frame;
        test_timeout;
        test_run_reload;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
